msi_l1_cache_ctrl: RTL and testbench

- Per-core private L1 data cache controller implementing the MSI coherence protocol.
- Sits directly downstream of a processor core: consumes its read/write/address/write_data requests and returns fetched_data.
- Upstream of the shared snooping bus and arbiter.
- Direct-mapped, one 32-bit word per line, write-back and write-allocate.

---
 rtl/msi_l1_cache_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_msi_l1_cache_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_l1_cache_ctrl.sv
// rtl/msi_l1_cache_ctrl.sv - direct-mapped write-back L1 data cache controller, MSI snooping
// One word per line; snoop updates are applied before the core-side lookup in the same cycle.
module msi_l1_cache_ctrl #(
  parameter int   NUM_LINES = 16,
  parameter int   ADDR_W    = 9,
  parameter int   DATA_W    = 32,
  parameter logic CORE_ID   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] fetched_data,
  output logic              core_ready,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_done,
  input  logic              snoop_valid,
  input  logic              snoop_src,
  input  logic [1:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_flush,
  output logic [DATA_W-1:0] snoop_data
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;
  localparam logic [1:0] CMD_NONE = 2'd0, CMD_RD = 2'd1, CMD_RDX = 2'd2, CMD_FLUSH = 2'd3;

  typedef enum logic [2:0] {IDLE, COMPARE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE} fsm_t;

  fsm_t              state_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [DATA_W-1:0] data_q [NUM_LINES];
  logic [1:0]        st_q   [NUM_LINES];
  logic              core_ready_q, bus_req_q, snoop_flush_q;
  logic [1:0]        bus_cmd_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] fetched_q, bus_wdata_q, snoop_data_q;

  logic [IDX_W-1:0]  req_idx, snp_idx;
  logic [TAG_W-1:0]  req_tag, snp_tag;
  logic              snp_hit, snp_flush_d, req_hit;
  logic [1:0]        snp_st_d, cur_st;

  always_comb begin
    req_idx     = addr_q[IDX_W-1:0];
    req_tag     = addr_q[ADDR_W-1:IDX_W];
    snp_idx     = snoop_addr[IDX_W-1:0];
    snp_tag     = snoop_addr[ADDR_W-1:IDX_W];
    snp_hit     = snoop_valid && (snoop_src != CORE_ID) &&
                  (tag_q[snp_idx] == snp_tag) && (st_q[snp_idx] != ST_I);
    snp_st_d    = st_q[snp_idx];
    snp_flush_d = 1'b0;
    if (snp_hit) begin
      if (snoop_cmd == CMD_RD && st_q[snp_idx] == ST_M) begin
        snp_st_d    = ST_S;
        snp_flush_d = 1'b1;
      end else if (snoop_cmd == CMD_RDX) begin
        snp_st_d    = ST_I;
        snp_flush_d = (st_q[snp_idx] == ST_M);
      end
    end
    // Lookup sees the line state as it will be after this cycle's snoop.
    cur_st  = (snp_hit && snp_idx == req_idx) ? snp_st_d : st_q[req_idx];
    req_hit = (tag_q[req_idx] == req_tag) && (cur_st != ST_I);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      core_ready_q  <= 1'b0;
      fetched_q     <= '0;
      bus_req_q     <= 1'b0;
      bus_cmd_q     <= CMD_NONE;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      snoop_flush_q <= 1'b0;
      snoop_data_q  <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        st_q[i]   <= ST_I;
      end
    end else begin
      snoop_flush_q <= snp_flush_d;
      snoop_data_q  <= snp_flush_d ? data_q[snp_idx] : '0;
      if (snp_hit) st_q[snp_idx] <= snp_st_d;

      case (state_q)
        IDLE: begin
          if (core_req && (read || write)) begin
            wr_q    <= write;
            addr_q  <= address;
            wdata_q <= write_data;
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          if (req_hit && (!wr_q || cur_st == ST_M)) begin
            if (wr_q) data_q[req_idx] <= wdata_q;
            else      fetched_q       <= data_q[req_idx];
            core_ready_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            bus_req_q <= 1'b1;
            state_q   <= (!req_hit && cur_st == ST_M) ? WB_REQ : FILL_REQ;
          end
        end
        WB_REQ: begin
          // A peer may have taken the dirty victim while we waited for the bus.
          if (cur_st != ST_M) begin
            state_q <= FILL_REQ;
          end else if (bus_gnt) begin
            bus_cmd_q   <= CMD_FLUSH;
            bus_addr_q  <= {tag_q[req_idx], req_idx};
            bus_wdata_q <= data_q[req_idx];
            state_q     <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (bus_done) begin
            st_q[req_idx] <= ST_I;
            bus_cmd_q     <= CMD_NONE;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            state_q       <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (bus_gnt) begin
            bus_cmd_q  <= wr_q ? CMD_RDX : CMD_RD;
            bus_addr_q <= addr_q;
            state_q    <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (bus_done) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= wr_q ? wdata_q : bus_rdata;
            st_q[req_idx]   <= wr_q ? ST_M : ST_S;
            if (!wr_q) fetched_q <= bus_rdata;
            bus_req_q    <= 1'b0;
            bus_cmd_q    <= CMD_NONE;
            bus_addr_q   <= '0;
            core_ready_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          core_ready_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetched_data = fetched_q;
  assign core_ready   = core_ready_q;
  assign bus_req      = bus_req_q;
  assign bus_cmd      = bus_cmd_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign snoop_flush  = snoop_flush_q;
  assign snoop_data   = snoop_data_q;

endmodule

// File: tb/tb_msi_l1_cache_ctrl.sv
// tb/tb_msi_l1_cache_ctrl.sv - self-checking bench for msi_l1_cache_ctrl
// Bus partner grants and completes after two cycles each; a per-index cache model predicts traffic.
module tb_msi_l1_cache_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        core_req = 1'b0, read = 1'b0, write = 1'b0;
  logic [8:0]  address = '0;
  logic [31:0] write_data = '0, fetched_data;
  logic        core_ready, bus_req, bus_gnt = 1'b0, bus_done = 1'b0;
  logic [1:0]  bus_cmd;
  logic [8:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata = '0;
  logic        snoop_valid = 1'b0, snoop_src = 1'b0, snoop_flush;
  logic [1:0]  snoop_cmd = '0;
  logic [8:0]  snoop_addr = '0;
  logic [31:0] snoop_data;

  msi_l1_cache_ctrl #(.NUM_LINES(16), .ADDR_W(9), .DATA_W(32), .CORE_ID(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .read(read), .write(write),
    .address(address), .write_data(write_data), .fetched_data(fetched_data),
    .core_ready(core_ready), .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_done(bus_done),
    .snoop_valid(snoop_valid), .snoop_src(snoop_src), .snoop_cmd(snoop_cmd),
    .snoop_addr(snoop_addr), .snoop_flush(snoop_flush), .snoop_data(snoop_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int gcnt, dcnt;
  bit granted;
  logic [31:0] mem [512];
  logic [1:0]  oc [$];
  logic [8:0]  oa [$];
  logic [31:0] ow [$];
  logic [8:0]  m_a [16];
  int          m_s [16];
  logic [31:0] m_d [16];

  task automatic bus_step();
    bus_gnt  = 1'b0;
    bus_done = 1'b0;
    if (bus_cmd != 2'd0) begin
      dcnt++;
      if (dcnt >= 2) begin
        bus_done = 1'b1; dcnt = 0; granted = 1'b0;
        oc.push_back(bus_cmd); oa.push_back(bus_addr); ow.push_back(bus_wdata);
        bus_rdata = mem[bus_addr];
      end
    end else if (bus_req && !granted) begin
      gcnt++;
      if (gcnt >= 2) begin bus_gnt = 1'b1; granted = 1'b1; gcnt = 0; end
    end
  endtask

  task automatic do_req(input bit wr, input logic [8:0] a, input logic [31:0] wd,
                        output logic [31:0] fd, output int lat, output int reqc, output bit tmo);
    oc.delete(); oa.delete(); ow.delete();
    gcnt = 0; dcnt = 0; granted = 1'b0;
    @(negedge clk);
    core_req = 1'b1; read = !wr; write = wr; address = a; write_data = wd;
    lat = 1; reqc = 0; tmo = 1'b1; fd = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      core_req = 1'b0;
      lat++;
      if (bus_req) reqc++;
      if (core_ready) begin
        fd = fetched_data; tmo = 1'b0; bus_gnt = 1'b0; bus_done = 1'b0;
        break;
      end
      bus_step();
    end
  endtask

  task automatic do_snoop(input bit src, input logic [1:0] cmd, input logic [8:0] a,
                          output bit fl, output logic [31:0] d);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_src = src; snoop_cmd = cmd; snoop_addr = a;
    @(negedge clk);
    snoop_valid = 1'b0;
    fl = snoop_flush; d = snoop_data;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; bus_gnt = 1'b0; bus_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (core_ready !== 1'b0 || bus_req !== 1'b0 || bus_cmd !== 2'd0 || fetched_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b req=%b cmd=%0d fd=%h, required all 0",
               core_ready, bus_req, bus_cmd, fetched_data);
    end
    n_cmp++;
    if (snoop_flush !== 1'b0 || snoop_data !== 32'd0 || bus_addr !== 9'd0 || bus_wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_snoop_bus: flush=%b sdata=%h baddr=%h bwd=%h, required all 0",
               snoop_flush, snoop_data, bus_addr, bus_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cold_read();
    logic [31:0] fd; int lat, reqc; bit tmo;
    mem[9'h025] = 32'hDEADBEEF;
    do_req(1'b0, 9'h025, 32'd0, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || oc.size() != 1 || oc[0] !== 2'd1 || oa[0] !== 9'h025) begin
      n_bad++; $display("FAIL cold_read_bus: tmo=%b ntx=%0d, required one BusRd 0x025", tmo, oc.size());
    end
    n_cmp++;
    if (fd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cold_read_data: got %h want deadbeef", fd); end
    do_req(1'b0, 9'h025, 32'd0, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || lat != 3 || reqc != 0 || fd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL read_hit: lat=%0d reqc=%0d fd=%h, required lat 3 reqc 0 deadbeef", lat, reqc, fd);
    end
  endtask

  task automatic test_write_upgrade();
    logic [31:0] fd; int lat, reqc; bit tmo;
    do_req(1'b1, 9'h025, 32'h12345678, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || oc.size() != 1 || oc[0] !== 2'd2 || oa[0] !== 9'h025) begin
      n_bad++; $display("FAIL upgrade_bus: tmo=%b ntx=%0d, required one BusRdX 0x025", tmo, oc.size());
    end
    do_req(1'b1, 9'h025, 32'h12345678, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || lat != 3 || reqc != 0) begin
      n_bad++; $display("FAIL write_hit_m: lat=%0d reqc=%0d, required lat 3 reqc 0", lat, reqc);
    end
    do_req(1'b0, 9'h025, 32'd0, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || lat != 3 || fd !== 32'h12345678) begin
      n_bad++; $display("FAIL read_after_write: lat=%0d fd=%h, required lat 3 12345678", lat, fd);
    end
  endtask

  task automatic test_evict();
    logic [31:0] fd; int lat, reqc; bit tmo;
    mem[9'h035] = 32'hCAFE0035;
    do_req(1'b0, 9'h035, 32'd0, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || oc.size() != 2) begin
      n_bad++; $display("FAIL evict_count: tmo=%b ntx=%0d, required 2", tmo, oc.size());
    end else begin
      n_cmp++;
      if (oc[0] !== 2'd3 || oa[0] !== 9'h025 || ow[0] !== 32'h12345678) begin
        n_bad++; $display("FAIL evict_flush: cmd=%0d addr=%h data=%h, required 3 025 12345678", oc[0], oa[0], ow[0]);
      end
      n_cmp++;
      if (oc[1] !== 2'd1 || oa[1] !== 9'h035) begin
        n_bad++; $display("FAIL evict_fill: cmd=%0d addr=%h, required 1 035", oc[1], oa[1]);
      end
    end
    n_cmp++;
    if (fd !== 32'hCAFE0035) begin n_bad++; $display("FAIL evict_data: got %h want cafe0035", fd); end
    mem[9'h025] = 32'h12345678;
  endtask

  task automatic test_snoop();
    logic [31:0] fd, d; int lat, reqc; bit tmo, fl;
    do_req(1'b1, 9'h025, 32'h12345678, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || oc.size() != 1 || oc[0] !== 2'd2) begin
      n_bad++; $display("FAIL snoop_setup: tmo=%b ntx=%0d, required one BusRdX", tmo, oc.size());
    end
    do_snoop(1'b1, 2'd1, 9'h025, fl, d);
    n_cmp++;
    if (fl !== 1'b1 || d !== 32'h12345678) begin
      n_bad++; $display("FAIL snoop_busrd_m: flush=%b data=%h, required 1 12345678", fl, d);
    end
    do_snoop(1'b1, 2'd2, 9'h025, fl, d);
    n_cmp++;
    if (fl !== 1'b0 || d !== 32'd0) begin
      n_bad++; $display("FAIL snoop_busrdx_s: flush=%b data=%h, required 0 0", fl, d);
    end
    do_req(1'b0, 9'h025, 32'd0, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || oc.size() != 1 || oc[0] !== 2'd1 || fd !== 32'h12345678) begin
      n_bad++; $display("FAIL snoop_inval_miss: ntx=%0d fd=%h, required one BusRd 12345678", oc.size(), fd);
    end
  endtask

  task automatic test_own_snoop();
    logic [31:0] fd, d; int lat, reqc; bit tmo, fl;
    do_req(1'b1, 9'h025, 32'hA5A5A5A5, fd, lat, reqc, tmo);
    do_snoop(1'b0, 2'd2, 9'h025, fl, d);
    n_cmp++;
    if (fl !== 1'b0 || d !== 32'd0) begin
      n_bad++; $display("FAIL own_snoop_flush: flush=%b data=%h, required 0 0", fl, d);
    end
    do_req(1'b1, 9'h025, 32'h5A5A5A5A, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || lat != 3 || reqc != 0) begin
      n_bad++; $display("FAIL own_snoop_state: lat=%0d reqc=%0d, required lat 3 reqc 0", lat, reqc);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] fd; int lat, reqc; bit tmo, seen;
    gcnt = 0; dcnt = 0; granted = 1'b0;
    @(negedge clk);
    core_req = 1'b1; read = 1'b1; write = 1'b0; address = 9'h047; write_data = '0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      core_req = 1'b0;
      if (bus_cmd != 2'd0) seen = 1'b1;
      else bus_step();
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rstfill_reach: fill command never observed"); end
    bus_gnt = 1'b0; bus_done = 1'b0; rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_req !== 1'b0 || core_ready !== 1'b0 || bus_cmd !== 2'd0) begin
      n_bad++; $display("FAIL rstfill_abort: req=%b ready=%b cmd=%0d, required 0 0 0", bus_req, core_ready, bus_cmd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 9'h047, 32'd0, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || oc.size() != 1 || oc[0] !== 2'd1 || fd !== mem[9'h047]) begin
      n_bad++; $display("FAIL rstfill_remiss: ntx=%0d fd=%h, required one BusRd %h", oc.size(), fd, mem[9'h047]);
    end
    do_req(1'b0, 9'h025, 32'd0, fd, lat, reqc, tmo);
    n_cmp++;
    if (tmo || oc.size() != 1 || oc[0] !== 2'd1) begin
      n_bad++; $display("FAIL rst_clears_m: ntx=%0d, required one BusRd and no Flush", oc.size());
    end
  endtask

  task automatic test_random();
    logic [1:0] ec [$]; logic [8:0] ea [$]; logic [31:0] ew [$];
    logic [31:0] fd, d, wd, efd, ed; logic [8:0] a; logic [1:0] cmd;
    int lat, reqc, idx; bit tmo, wr, hit, fl, efl, src, ok;
    pulse_reset();
    for (int i = 0; i < 16; i++) begin m_s[i] = 0; m_a[i] = '0; m_d[i] = '0; end
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    for (int n = 0; n < 120; n++) begin
      a   = 9'(($urandom_range(0, 3) << 4) | $urandom_range(3, 4));
      idx = int'(a[3:0]);
      if ($urandom_range(0, 3) != 0) begin
        wr = 1'($urandom_range(0, 1)); wd = $urandom;
        ec.delete(); ea.delete(); ew.delete();
        hit = (m_s[idx] != 0) && (m_a[idx] == a);
        efd = '0;
        if (hit && !wr) efd = m_d[idx];
        else if (hit && m_s[idx] == 2) m_d[idx] = wd;
        else if (hit) begin
          ec.push_back(2'd2); ea.push_back(a); ew.push_back('0);
          m_s[idx] = 2; m_d[idx] = wd;
        end else begin
          if (m_s[idx] == 2) begin
            ec.push_back(2'd3); ea.push_back(m_a[idx]); ew.push_back(m_d[idx]);
            mem[m_a[idx]] = m_d[idx];
          end
          ec.push_back(wr ? 2'd2 : 2'd1); ea.push_back(a); ew.push_back('0);
          efd = mem[a]; m_a[idx] = a; m_s[idx] = wr ? 2 : 1; m_d[idx] = wr ? wd : mem[a];
        end
        do_req(wr, a, wd, fd, lat, reqc, tmo);
        n_cmp++;
        if (tmo) begin n_bad++; $display("FAIL rnd_timeout: op %0d addr %h no core_ready in 200 cycles", n, a); end
        ok = (oc.size() == ec.size());
        for (int k = 0; ok && k < ec.size(); k++)
          if (oc[k] !== ec[k] || oa[k] !== ea[k] || (ec[k] == 2'd3 && ow[k] !== ew[k])) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL rnd_bus: op %0d wr=%b addr %h got %0d tx (first cmd %0d), required %0d tx (first cmd %0d)",
                   n, wr, a, oc.size(), (oc.size() > 0) ? oc[0] : 2'd0, ec.size(), (ec.size() > 0) ? ec[0] : 2'd0);
        end
        if (!wr) begin
          n_cmp++;
          if (fd !== efd) begin n_bad++; $display("FAIL rnd_data: op %0d addr %h got %h want %h", n, a, fd, efd); end
        end
        if (ec.size() == 0) begin
          n_cmp++;
          if (lat != 3 || reqc != 0) begin
            n_bad++; $display("FAIL rnd_hit_lat: op %0d lat=%0d reqc=%0d, required 3 0", n, lat, reqc);
          end
        end
      end else begin
        src = 1'($urandom_range(0, 1)); cmd = 2'($urandom_range(1, 3));
        efl = 1'b0; ed = '0;
        if (src != 1'b0 && m_s[idx] != 0 && m_a[idx] == a) begin
          if (cmd == 2'd1 && m_s[idx] == 2) begin efl = 1'b1; ed = m_d[idx]; m_s[idx] = 1; end
          else if (cmd == 2'd2) begin
            if (m_s[idx] == 2) begin efl = 1'b1; ed = m_d[idx]; end
            m_s[idx] = 0;
          end
        end
        do_snoop(src, cmd, a, fl, d);
        n_cmp++;
        if (fl !== efl || d !== ed) begin
          n_bad++; $display("FAIL rnd_snoop: op %0d src=%b cmd=%0d addr %h got %b/%h want %b/%h",
                            n, src, cmd, a, fl, d, efl, ed);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_read();
    test_write_upgrade();
    test_evict();
    test_snoop();
    test_own_snoop();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
